// File: rtl/fetch_unit_pkg.sv
// Shared types and defaults for the dual-issue fetch unit and its queue.
// Latency: n/a (types, constants and a pure helper only).
// Backpressure: n/a.
package fetch_unit_pkg;

  localparam int          QDEPTH_DEFAULT   = 4;
  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

  // One fetched instruction as it sits in the queue.
  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
    logic        pred;
  } fetch_entry_t;

  // Static backward-taken: only a negative offset on a real branch is taken.
  function automatic logic predict_taken(input logic br_en, input logic [31:0] br_imm);
    return br_en & br_imm[31];
  endfunction

endpackage

// File: rtl/fetch_unit_if.sv
// Bundles the instruction-memory, pre-decode, redirect and decode-side signals.
// Latency: n/a (wiring only).
// Backpressure: dec_ready consumes every asserted dec_valid entry in the same cycle.
// master = fetch unit side, slave = memory / pre-decoder / decode / execute side.
interface fetch_unit_if;

  logic [31:0] imem_addr;
  logic [31:0] imem_inst0;
  logic [31:0] imem_inst1;
  logic        br_en0;
  logic        br_en1;
  logic [31:0] br_imm0;
  logic [31:0] br_imm1;
  logic        flush;
  logic [31:0] flush_pc;
  logic        dec_valid0;
  logic        dec_valid1;
  logic [31:0] dec_pc0;
  logic [31:0] dec_pc1;
  logic [31:0] dec_inst0;
  logic [31:0] dec_inst1;
  logic        dec_pred0;
  logic        dec_pred1;
  logic        dec_ready;

  modport master (
    output imem_addr,
    input  imem_inst0, imem_inst1,
    input  br_en0, br_en1, br_imm0, br_imm1,
    input  flush, flush_pc,
    output dec_valid0, dec_valid1, dec_pc0, dec_pc1,
    output dec_inst0, dec_inst1, dec_pred0, dec_pred1,
    input  dec_ready
  );

  modport slave (
    input  imem_addr,
    output imem_inst0, imem_inst1,
    output br_en0, br_en1, br_imm0, br_imm1,
    output flush, flush_pc,
    input  dec_valid0, dec_valid1, dec_pc0, dec_pc1,
    input  dec_inst0, dec_inst1, dec_pred0, dec_pred1,
    output dec_ready
  );

endinterface

// File: rtl/fetch_queue.sv
// 2-in/2-out circular fetch queue; enqueue and dequeue 0-2 entries per cycle each.
// Latency: an entry written on a rising edge is visible at the head outputs after that edge.
// Backpressure: none internally; the caller must only enqueue when count leaves room.
// Ports: clk, rst (async active-low), clear (sync empty), enq_cnt/enq_dat0/1,
//        deq_cnt, count (occupancy), head_dat0/1 (entries at head and head+1).
module fetch_queue
  import fetch_unit_pkg::*;
#(
  parameter  int QDEPTH = QDEPTH_DEFAULT,
  localparam int PW     = $clog2(QDEPTH),
  localparam int CW     = PW + 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clear,
  input  logic [1:0]   enq_cnt,
  input  fetch_entry_t enq_dat0,
  input  fetch_entry_t enq_dat1,
  input  logic [1:0]   deq_cnt,
  output logic [CW-1:0] count,
  output fetch_entry_t head_dat0,
  output fetch_entry_t head_dat1
);

  fetch_entry_t    mem [QDEPTH];
  logic [PW-1:0]   head;
  logic [PW-1:0]   tail;
  logic [PW-1:0]   head_p1;
  logic [PW-1:0]   tail_p1;

  // Pointers are exactly log2(QDEPTH) bits, so +1 wraps for free.
  assign head_p1   = head + PW'(1);
  assign tail_p1   = tail + PW'(1);
  assign head_dat0 = mem[head];
  assign head_dat1 = mem[head_p1];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else if (clear) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      head  <= head + PW'(deq_cnt);
      tail  <= tail + PW'(enq_cnt);
      count <= count + CW'(enq_cnt) - CW'(deq_cnt);
    end
  end

  // Payload storage is deliberately left unreset; validity comes from count.
  always_ff @(posedge clk) begin
    if (!clear && enq_cnt != 2'd0) mem[tail]    <= enq_dat0;
    if (!clear && enq_cnt == 2'd2) mem[tail_p1] <= enq_dat1;
  end

endmodule

// File: rtl/fetch_unit.sv
// Two-wide instruction fetch with static backward-taken prediction feeding a fetch queue.
// Latency: imem_addr is the PC register; a fetched pair reaches dec_* one cycle later.
// Backpressure: fetch stalls (PC held) while fewer than two queue slots are free; flush overrides all.
// Ports: clk, rst (async active-low), bus (fetch_unit_if.master: imem, pre-decode, flush, decode).
module fetch_unit
  import fetch_unit_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT,
  parameter int          QDEPTH   = QDEPTH_DEFAULT
) (
  input  logic         clk,
  input  logic         rst,
  fetch_unit_if.master bus
);

  localparam int CW = $clog2(QDEPTH) + 1;
  localparam logic [CW-1:0] FIRE_MAX = CW'(QDEPTH - 2);

  logic [31:0]   pc;
  logic [31:0]   pc_next;
  logic          pred0;
  logic          pred1;
  logic          fetch_fire;
  logic [1:0]    enq_cnt;
  logic [1:0]    deq_cnt;
  logic [CW-1:0] count;
  logic          valid0;
  logic          valid1;
  fetch_entry_t  slot0;
  fetch_entry_t  slot1;
  fetch_entry_t  head0;
  fetch_entry_t  head1;

  assign bus.imem_addr = pc;

  assign pred0 = predict_taken(bus.br_en0, bus.br_imm0);
  assign pred1 = predict_taken(bus.br_en1, bus.br_imm1);

  // Fire only with room for a full pair, judged on occupancy before dequeue.
  assign fetch_fire = !bus.flush && (count <= FIRE_MAX);

  always_comb begin
    slot0   = '{pc: pc,          inst: bus.imem_inst0, pred: pred0};
    slot1   = '{pc: pc + 32'd4,  inst: bus.imem_inst1, pred: pred1};
    enq_cnt = 2'd0;
    if (fetch_fire) enq_cnt = pred0 ? 2'd1 : 2'd2;
  end

  // Valids drop in the flush cycle, which also suppresses the dequeue.
  assign valid0  = !bus.flush && (count != '0);
  assign valid1  = !bus.flush && (count >= CW'(2));
  assign deq_cnt = bus.dec_ready ? ({1'b0, valid0} + {1'b0, valid1}) : 2'd0;

  always_comb begin
    pc_next = pc;
    if (bus.flush)      pc_next = bus.flush_pc;
    else if (fetch_fire) begin
      if (pred0)        pc_next = pc + bus.br_imm0;
      else if (pred1)   pc_next = pc + 32'd4 + bus.br_imm1;
      else              pc_next = pc + 32'd8;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) pc <= RESET_PC;
    else      pc <= pc_next;
  end

  fetch_queue #(.QDEPTH(QDEPTH)) u_queue (
    .clk       (clk),
    .rst       (rst),
    .clear     (bus.flush),
    .enq_cnt   (enq_cnt),
    .enq_dat0  (slot0),
    .enq_dat1  (slot1),
    .deq_cnt   (deq_cnt),
    .count     (count),
    .head_dat0 (head0),
    .head_dat1 (head1)
  );

  assign bus.dec_valid0 = valid0;
  assign bus.dec_valid1 = valid1;
  assign bus.dec_pc0    = head0.pc;
  assign bus.dec_pc1    = head1.pc;
  assign bus.dec_inst0  = head0.inst;
  assign bus.dec_inst1  = head1.inst;
  assign bus.dec_pred0  = head0.pred;
  assign bus.dec_pred1  = head1.pred;

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: a small program image drives imem/pre-decode, a model
// PC tracks fetches and an expected-entry queue scores what decode receives.
// Finishes on its own after a fixed, bounded stimulus sequence.
module tb_fetch_unit;
  import fetch_unit_pkg::*;

  localparam int          QD   = QDEPTH_DEFAULT;
  localparam logic [31:0] RPC  = RESET_PC_DEFAULT;

  logic clk;
  logic rst;
  fetch_unit_if bus ();

  fetch_unit dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  fetch_entry_t exp_q[$];
  logic [31:0]  mpc;

  // Program image: instruction word and pre-decode info per address.
  function automatic logic [31:0] inst_of(input logic [31:0] a);
    return {a[15:0], ~a[15:0]} ^ 32'h1357_9BDF;
  endfunction

  function automatic logic br_en_of(input logic [31:0] a);
    return (a == 32'h14) || (a == 32'h40) || (a == 32'h20C);
  endfunction

  // Non-branches still carry a negative offset so br_en must gate prediction.
  function automatic logic [31:0] br_imm_of(input logic [31:0] a);
    case (a)
      32'h14:  return 32'd32;          // forward: not taken
      32'h40:  return 32'hFFFF_FFF0;   // -16: taken from slot0
      32'h20C: return 32'hFFFF_FFF4;   // -12: taken from slot1
      default: return 32'hFFFF_FF00;
    endcase
  endfunction

  always_comb begin
    bus.imem_inst0 = inst_of(bus.imem_addr);
    bus.imem_inst1 = inst_of(bus.imem_addr + 32'd4);
    bus.br_en0     = br_en_of(bus.imem_addr);
    bus.br_en1     = br_en_of(bus.imem_addr + 32'd4);
    bus.br_imm0    = br_imm_of(bus.imem_addr);
    bus.br_imm1    = br_imm_of(bus.imem_addr + 32'd4);
  end

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, act, exp, $time);
    end
  endtask

  // One clock cycle, entered and left at a falling edge.
  task automatic cycle(input logic rdy, input logic fl, input logic [31:0] fpc);
    int           occ;
    fetch_entry_t e;
    logic [31:0]  i0, i1;
    logic         p0, p1;
    bus.dec_ready = rdy;
    bus.flush     = fl;
    bus.flush_pc  = fpc;
    #1;
    occ = exp_q.size();
    check_eq("imem_addr",  bus.imem_addr, mpc);
    check_eq("dec_valid0", 32'(bus.dec_valid0), 32'(!fl && occ >= 1));
    check_eq("dec_valid1", 32'(bus.dec_valid1), 32'(!fl && occ >= 2));
    if (fl) begin
      exp_q.delete();
      mpc = fpc;
    end else begin
      if (rdy && occ >= 1) begin
        e = exp_q.pop_front();
        check_eq("dec_pc0",   bus.dec_pc0, e.pc);
        check_eq("dec_inst0", bus.dec_inst0, e.inst);
        check_eq("dec_pred0", 32'(bus.dec_pred0), 32'(e.pred));
      end
      if (rdy && occ >= 2) begin
        e = exp_q.pop_front();
        check_eq("dec_pc1",   bus.dec_pc1, e.pc);
        check_eq("dec_inst1", bus.dec_inst1, e.inst);
        check_eq("dec_pred1", 32'(bus.dec_pred1), 32'(e.pred));
      end
      if (occ <= QD - 2) begin
        i0 = br_imm_of(mpc);
        i1 = br_imm_of(mpc + 32'd4);
        p0 = br_en_of(mpc) && i0[31];
        p1 = br_en_of(mpc + 32'd4) && i1[31];
        exp_q.push_back('{pc: mpc, inst: inst_of(mpc), pred: p0});
        if (p0) mpc = mpc + i0;
        else begin
          exp_q.push_back('{pc: mpc + 32'd4, inst: inst_of(mpc + 32'd4), pred: p1});
          mpc = p1 ? (mpc + 32'd4 + i1) : (mpc + 32'd8);
        end
      end
    end
    @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic found;
    rst           = 1'b0;
    bus.dec_ready = 1'b0;
    bus.flush     = 1'b0;
    bus.flush_pc  = 32'h0;
    repeat (2) @(negedge clk);
    check_eq("rst_imem_addr",  bus.imem_addr, RPC);
    check_eq("rst_dec_valid0", 32'(bus.dec_valid0), 32'd0);
    check_eq("rst_dec_valid1", 32'(bus.dec_valid1), 32'd0);

    rst = 1'b1;
    mpc = RPC;
    exp_q.delete();

    // Straight-line code, slot1 forward branch at 0x14, slot0 backward at 0x40.
    repeat (12) cycle(1'b1, 1'b0, 32'h0);

    // Decode stall: queue fills and PC holds, then drains two per cycle.
    repeat (5) cycle(1'b0, 1'b0, 32'h0);
    repeat (8) cycle(1'b1, 1'b0, 32'h0);

    // Flush while exactly three entries are queued and decode is ready.
    found = 1'b0;
    for (int i = 0; i < 200 && !found; i++) begin
      if (exp_q.size() == 3) begin
        cycle(1'b1, 1'b1, 32'h200);
        found = 1'b1;
      end else begin
        cycle(1'($urandom_range(0, 1)), 1'b0, 32'h0);
      end
    end
    check_eq("flush_with_3_reached", 32'(found), 32'd1);

    // 0x200 region: slot1 backward branch at 0x20C loops back to 0x200.
    repeat (8) cycle(1'b1, 1'b0, 32'h0);

    // Flush with a stalled, full queue to an address whose pair wraps past 2^32.
    repeat (3) cycle(1'b0, 1'b0, 32'h0);
    cycle(1'b0, 1'b1, 32'hFFFF_FFF8);
    repeat (20) cycle(1'($urandom_range(0, 1)), 1'b0, 32'h0);

    // Asynchronous reset mid-stream with a non-empty queue.
    repeat (3) cycle(1'b0, 1'b0, 32'h0);
    bus.dec_ready = 1'b1;
    #2 rst = 1'b0;
    #1;
    check_eq("async_rst_valid0", 32'(bus.dec_valid0), 32'd0);
    check_eq("async_rst_valid1", 32'(bus.dec_valid1), 32'd0);
    check_eq("async_rst_pc",     bus.imem_addr, RPC);
    exp_q.delete();
    mpc = RPC;
    @(negedge clk);
    rst = 1'b1;
    repeat (10) cycle(1'($urandom_range(0, 1)), 1'b0, 32'h0);
    repeat (4) cycle(1'b1, 1'b0, 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000, meaning the PC loaded at reset.
REQ-002 Parameter QDEPTH, default 4, meaning the fetch-queue entry count; power of two, at least 4.
REQ-003 clk  input  1  the single clock; all state updates on its rising edge.
REQ-004 rst  input  1  reset, asynchronous and active-low.
REQ-005 imem_addr  output  32  fetch PC; the combinational instruction memory returns the words at imem_addr and imem_addr+4 in the same cycle.
REQ-006 imem_inst0, imem_inst1  input  32 each  instruction words at imem_addr and imem_addr+4.
REQ-007 br_en0, br_en1  input  1 each  pre-decoder branch flag for slot0 and slot1.
REQ-008 br_imm0, br_imm1  input  32 each  pre-decoder sign-extended B-type offset for slot0 and slot1.
REQ-009 flush  input  1  execute-stage mispredict redirect.
REQ-010 flush_pc  input  32  redirect target, valid when flush=1.
REQ-011 dec_valid0, dec_valid1  output  1 each  queue head and head+1 entries are valid.
REQ-012 dec_pc0, dec_pc1, dec_inst0, dec_inst1  output  32 each  PC and instruction of the head and head+1 entries.
REQ-013 dec_pred0, dec_pred1  output  1 each  predicted-taken flag of the head and head+1 entries.
REQ-014 dec_ready  input  1  decode consumes every asserted dec_valid entry this cycle.

Function
REQ-015 Prediction is static backward-taken: slot k is predicted taken iff br_enk=1 and br_immk[31]=1.
REQ-016 fetch_fire = !flush and count <= QDEPTH-2, where count is the occupancy before this cycle's dequeue.
REQ-017 On fetch_fire, slot0 {imem_addr, imem_inst0, pred0} is always enqueued.
REQ-018 If slot0 is predicted taken, slot1 is not enqueued and PC <= imem_addr + br_imm0.
REQ-019 Otherwise slot1 {imem_addr+4, imem_inst1, pred1} is enqueued at tail+1.
REQ-020 In that case, PC <= imem_addr+4+br_imm1 if pred1=1, else PC <= imem_addr+8.
REQ-021 When fetch_fire=0 and flush=0, PC holds and nothing is enqueued.
REQ-022 All PC arithmetic is 32-bit modulo 2^32; no alignment check.
REQ-023 Dequeue count = dec_ready ? (dec_valid0 + dec_valid1) : 0.
REQ-024 dec_valid0 = (count>=1) and dec_valid1 = (count>=2); both are cleared in the flush cycle.
REQ-025 Head and tail pointers are log2(QDEPTH) bits and wrap modulo QDEPTH.
REQ-026 Simultaneous enqueue and dequeue apply in the same cycle: count_next = count + enq - deq.
REQ-027 On flush (highest priority): count, head and tail <= 0; PC <= flush_pc; no enqueue.
REQ-028 A flush discards any dequeue that cycle; the dec_* outputs in the flush cycle are don't-care apart from the valid bits (REQ-024).
REQ-029 imem_addr equals the PC register (zero combinational delay from PC).

Reset
REQ-030 While rst=0: PC=RESET_PC, count=0, head=0, tail=0, dec_valid0=dec_valid1=0.
REQ-031 Queue payload storage is not reset.
REQ-032 Reset asserted mid-operation discards all queued entries immediately (asynchronous).
REQ-033 Fetch resumes at RESET_PC on the first rising edge after rst deasserts.

Structure
REQ-034 A shared package holds the fetch-entry struct {pc[31:0], inst[31:0], pred}, QDEPTH_DEFAULT and RESET_PC_DEFAULT.
REQ-035 The queue is one sub-module, fetch_queue: 2-in/2-out, variable enqueue and dequeue counts of 0-2.
REQ-036 Prediction and PC-next logic live in fetch_unit itself.

Verification
REQ-037 Reset release, straight-line code, dec_ready=1 -> imem_addr sequence 0,8,16,...; each cycle delivers pairs (0,4),(8,12),... with pred=0.
REQ-038 Slot0 at PC 0x40 is a branch with imm=-16 -> only 0x40 enqueued with pred0=1; next imem_addr=0x30.
REQ-039 Slot1 forward branch (br_en1=1, imm=+32) at PC 0x10 -> both enqueued with pred=0; next PC=0x18.
REQ-040 dec_ready=0 for 5 cycles -> queue fills to 4 and stalls with PC held; on dec_ready=1, two entries drain per cycle and fetch restarts; no loss or duplication across pointer wrap.
REQ-041 flush=1 with flush_pc=0x200 while the queue holds 3 entries and dec_ready=1 -> next cycle count=0, imem_addr=0x200, no entry is delivered twice.
REQ-042 rst pulsed low mid-stream -> dec_valid0/1 drop asynchronously; the first fetch after release is at RESET_PC.
